alu_seq: RTL and testbench

Parametrised, handshaked successor to the 5-bit combinational ALU. Operand B passes through a pre-shifter with four modes, then into an ALU that registers its result and flags. The ALU also provides a multi-cycle shift-add multiplier. It sits between the register-file read stage and writeback, with valid/ready on both sides.

---
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with pre-shifted operand B and registered result/flags
// Define ALU_MUL_EN to build the multi-cycle shift-add MUL datapath (opcode 110).
module alu_seq #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       shift_mode,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_ABS = 3'b101;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef ALU_MUL_EN
  localparam logic [2:0]     OP_MUL   = 3'b110;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;
  logic               fin;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state;
  logic             accept;
  logic             is_sub;
  logic             c_flag;
  logic             v_flag;
  logic [SHW-1:0]   rot;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH:0]   sum;
  logic [3:0]       flags_c;

  assign in_ready  = ~reset && (state == IDLE || (state == DONE && out_ready));
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    rot = SHW'(shamt % WIDTH);
    case (shift_mode)
      2'b00:   b_sh = b << shamt;
      2'b01:   b_sh = b >> shamt;
      2'b10:   b_sh = $unsigned($signed(b) >>> shamt);
      default: b_sh = (b >> rot) | (b << (WIDTH - int'(rot)));
    endcase

    // SUB shares the adder: a + ~b' + 1, so carry-out doubles as "no borrow"
    is_sub  = (alu_control == OP_SUB);
    bx      = is_sub ? ~b_sh : b_sh;
    sum     = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    abs_a   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    res_c   = '0;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    case (alu_control)
      OP_ADD, OP_SUB: begin
        res_c  = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res_c = a & b_sh;
      OP_OR:  res_c = a | b_sh;
      OP_XOR: res_c = a ^ b_sh;
      OP_ABS: begin
        res_c  = abs_a;
        v_flag = (a == MOST_NEG);
      end
      default: res_c = '0;
    endcase
    flags_c = {res_c[WIDTH-1], res_c == '0, c_flag, v_flag};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      result    <= '0;
      alu_flags <= '0;
`ifdef ALU_MUL_EN
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      fin       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (alu_control == OP_MUL) begin
              state  <= EXEC;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b_sh;
              cnt    <= '0;
              fin    <= 1'b0;
            end else
`endif
            begin
              state     <= DONE;
              result    <= res_c;
              alu_flags <= flags_c;
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
`ifdef ALU_MUL_EN
        // One multiplier bit per edge; the extra fin edge publishes the product
        EXEC: begin
          if (fin) begin
            state     <= DONE;
            result    <= acc[WIDTH-1:0];
            alu_flags <= {acc[WIDTH-1], acc[WIDTH-1:0] == '0, |acc[2*WIDTH-1:WIDTH], 1'b0};
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == CNT_LAST) fin <= 1'b1;
            else                 cnt <= cnt + SHW'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vector bench for alu_seq at WIDTH=8
// MUL sequences run when ALU_MUL_EN is defined; otherwise opcode 110 is checked as reserved.
module tb_alu_seq;

  logic       clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, result;
  logic [2:0] shamt, alu_control;
  logic [1:0] shift_mode;
  logic [3:0] alu_flags;
  int         total = 0;
  int         bad = 0;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, ABS = 3'b101, MUL = 3'b110, RSV = 3'b111;
  localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .shamt(shamt), .shift_mode(shift_mode), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .alu_flags(alu_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] shamt;
    logic [1:0] mode;
    logic [2:0] op;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] xa, input logic [7:0] xb, input logic [2:0] xs,
                       input logic [1:0] xm, input logic [2:0] xop);
    a = xa;
    b = xb;
    shamt = xs;
    shift_mode = xm;
    alu_control = xop;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive(v.a, v.b, v.shamt, v.mode, v.op);
    in_valid = 1'b1;
    out_ready = 1'b1;
    check($sformatf("v%0d in_ready", idx), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("v%0d out_valid", idx), out_valid, 1);
    check($sformatf("v%0d result", idx), result, v.res);
    check($sformatf("v%0d flags", idx), alu_flags, v.flg);
  endtask

  int cnt_hi;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(8'h00, 8'h00, 3'd0, LSL, ADD);

    vecs[0]  = '{8'h7F, 8'h01, 3'd0, LSL, ADD,  8'h80, 4'b1001};
    vecs[1]  = '{8'h10, 8'h01, 3'd4, LSL, SUB,  8'h00, 4'b0110};
    vecs[2]  = '{8'h00, 8'h81, 3'd1, ASR, OR_,  8'hC0, 4'b1000};
    vecs[3]  = '{8'h00, 8'h81, 3'd4, ROR, OR_,  8'h18, 4'b0000};
    vecs[4]  = '{8'h00, 8'h81, 3'd1, LSR, OR_,  8'h40, 4'b0000};
    vecs[5]  = '{8'hFB, 8'h00, 3'd0, LSL, ABS,  8'h05, 4'b0000};
    vecs[6]  = '{8'h80, 8'h00, 3'd0, LSL, ABS,  8'h80, 4'b1001};
    vecs[7]  = '{8'hF0, 8'h0F, 3'd4, LSL, AND_, 8'hF0, 4'b1000};
    vecs[8]  = '{8'hAA, 8'hAA, 3'd0, LSL, XOR_, 8'h00, 4'b0100};
    vecs[9]  = '{8'h00, 8'h01, 3'd0, LSL, SUB,  8'hFF, 4'b1000};
    vecs[10] = '{8'hFF, 8'h01, 3'd0, LSL, ADD,  8'h00, 4'b0110};
    vecs[11] = '{8'h12, 8'h34, 3'd0, LSL, RSV,  8'h00, 4'b0100};
    vecs[12] = '{8'h00, 8'h81, 3'd0, ROR, OR_,  8'h81, 4'b1000};
    vecs[13] = '{8'h80, 8'h01, 3'd0, LSL, SUB,  8'h7F, 4'b0011};
    vecs[14] = '{8'h00, 8'h03, 3'd7, LSL, ADD,  8'h80, 4'b1000};

    @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst result", result, 0);
    check("rst flags", alu_flags, 0);
    check("rst in_ready", in_ready, 0);
    reset = 1'b0;
    #1 check("post-rst in_ready", in_ready, 1);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Back-to-back single-cycle ops with out_ready held high
    @(negedge clk);
    drive(8'h01, 8'h02, 3'd0, LSL, ADD);
    in_valid = 1'b1;
    @(negedge clk);
    check("b2b first result", result, 8'h03);
    check("b2b in_ready in DONE", in_ready, 1);
    drive(8'h10, 8'h20, 3'd0, LSL, ADD);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b second valid", out_valid, 1);
    check("b2b second result", result, 8'h30);

    // Backpressure: output holds and new input is ignored
    @(negedge clk);
    drive(8'h0F, 8'hF0, 3'd0, LSL, XOR_);
    in_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    drive(8'hFF, 8'hFF, 3'd0, LSL, ADD);
    check("bp result", result, 8'hFF);
    check("bp flags", alu_flags, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d result", i), result, 8'hFF);
      check($sformatf("bp hold%0d flags", i), alu_flags, 4'b1000);
      check($sformatf("bp hold%0d in_ready", i), in_ready, 0);
      check($sformatf("bp hold%0d out_valid", i), out_valid, 1);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp release out_valid", out_valid, 0);

    // Asynchronous reset while holding a result in DONE
    drive(8'h01, 8'h01, 3'd0, LSL, ADD);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("done-rst pre result", result, 8'h02);
    #2 reset = 1'b1;
    #1 check("done-rst out_valid", out_valid, 0);
    check("done-rst result", result, 0);
    check("done-rst flags", alu_flags, 0);
    check("done-rst in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    #1 check("done-rst release in_ready", in_ready, 1);
    check("done-rst release out_valid", out_valid, 0);

`ifdef ALU_MUL_EN
    @(negedge clk);
    drive(8'h10, 8'h11, 3'd0, LSL, MUL);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt_hi = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1 if (out_valid) cnt_hi++;
    end
    check("mul early out_valid", cnt_hi, 0);
    @(posedge clk);
    #1 check("mul out_valid at 9", out_valid, 1);
    check("mul result", result, 8'h10);
    check("mul flags", alu_flags, 4'b0010);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check($sformatf("mul hold%0d result", i), result, 8'h10);
      check($sformatf("mul hold%0d in_ready", i), in_ready, 0);
      check($sformatf("mul hold%0d out_valid", i), out_valid, 1);
    end
    drive(8'h01, 8'h02, 3'd0, LSL, ADD);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 check("mul b2b in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("mul b2b add valid", out_valid, 1);
    check("mul b2b add result", result, 8'h03);
    check("mul b2b add flags", alu_flags, 4'b0000);
    @(posedge clk);

    // Reset three edges into a MUL
    #1 drive(8'h10, 8'h11, 3'd0, LSL, MUL);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("mul-rst out_valid", out_valid, 0);
    check("mul-rst result", result, 0);
    check("mul-rst flags", alu_flags, 0);
    check("mul-rst in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("mul-rst release in_ready", in_ready, 1);
    cnt_hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (out_valid) cnt_hi++;
    end
    check("mul-rst no stale valid", cnt_hi, 0);
`else
    @(negedge clk);
    drive(8'h10, 8'h11, 3'd0, LSL, MUL);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rsv-mul out_valid", out_valid, 1);
    check("rsv-mul result", result, 0);
    check("rsv-mul flags", alu_flags, 4'b0100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
